// File: rtl/clk_div_multi_pkg.sv
// Shared types and helpers for the multi-channel clock/tick divider.
package clk_div_multi_pkg;

  localparam int DIV_W_DEF       = 20;
  localparam int DEFAULT_DIV_DEF = 50000;

  typedef logic [DIV_W_DEF-1:0] div_t;

  // What a channel does on a given edge, in priority order.
  typedef enum logic [1:0] {
    ACT_RESTART  = 2'd0,
    ACT_TERMINAL = 2'd1,
    ACT_COUNT    = 2'd2
  } ch_act_e;

  // A zero divisor is meaningless, so it is treated as divide-by-one.
  function automatic logic [31:0] sat_div(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Divisor configuration bus: one write strobe, a channel index and the new divisor.
interface clk_div_multi_if #(
  parameter int N_CH  = 2,
  parameter int DIV_W = 20
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             cfg_wr;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;

  modport master (output cfg_wr, output cfg_ch, output cfg_div);
  modport slave  (input  cfg_wr, input  cfg_ch, input  cfg_div);

endinterface

// File: rtl/clk_div_multi_ch.sv
// One divider channel: counter, active/shadow divisor pair, square output and tick strobe.
module clk_div_multi_ch
  import clk_div_multi_pkg::*;
#(
  parameter int DIV_W     = DIV_W_DEF,
  parameter int RESET_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wr_div_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             pending_o
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(sat_div(32'(RESET_DIV)));

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  ch_act_e          act;

  always_comb begin
    act = ACT_COUNT;
    if (!en_i || sync_i) begin
      act = ACT_RESTART;
    end else if (cnt_q == div_q - DIV_W'(1)) begin
      act = ACT_TERMINAL;
    end
  end

  // A pending divisor is only swapped in at a period boundary (terminal or restart),
  // and a same-edge write lands in the shadow after the old shadow has been consumed.
  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    clk_d     = clk_q;
    tick_d    = 1'b0;

    case (act)
      ACT_RESTART: begin
        cnt_d = '0;
        clk_d = 1'b0;
      end
      ACT_TERMINAL: begin
        cnt_d  = '0;
        tick_d = 1'b1;
        clk_d  = ~clk_q;
      end
      ACT_COUNT: begin
        cnt_d = cnt_q + DIV_W'(1);
      end
      default: begin
        cnt_d = '0;
      end
    endcase

    if ((act != ACT_COUNT) && pending_q) begin
      div_d     = shadow_q;
      pending_d = 1'b0;
    end

    if (wr_i) begin
      shadow_d  = wr_div_i;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cnt_q     <= '0;
      div_q     <= RST_DIV;
      shadow_q  <= RST_DIV;
      pending_q <= 1'b0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_o     = clk_q;
  assign tick_o    = tick_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/tick generator with glitch-free divisor updates and phase sync.
module clk_div_multi
  import clk_div_multi_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [N_CH-1:0] en_i,
  input  logic            sync_i,
  clk_div_multi_if.slave  cfg,
  output logic [N_CH-1:0] clk_o,
  output logic [N_CH-1:0] tick_o,
  output logic [N_CH-1:0] pending_o
);

  logic [DIV_W-1:0] wrDiv;
  logic [N_CH-1:0]  wrSel;

  assign wrDiv = DIV_W'(sat_div(32'(cfg.cfg_div)));

  // Out-of-range channel indices match no channel, so such writes are dropped.
  always_comb begin
    wrSel = '0;
    for (int c = 0; c < N_CH; c++) begin
      wrSel[c] = cfg.cfg_wr && (32'(cfg.cfg_ch) == c);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : gen_ch
    clk_div_multi_ch #(
      .DIV_W     (DIV_W),
      .RESET_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .en_i      (en_i[g]),
      .sync_i    (sync_i),
      .wr_i      (wrSel[g]),
      .wr_div_i  (wrDiv),
      .clk_o     (clk_o[g]),
      .tick_o    (tick_o[g]),
      .pending_o (pending_o[g])
    );
  end

endmodule
